instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/mips_isa_pkg.sv | 72 +++++++
 rtl/instr_pack.sv | 45 ++++
 rtl/instr_encoder.sv | 129 ++++++++++++
 tb/tb_instr_encoder.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// MIPS-style ISA constants shared by the instruction encoder and decoder:
// mnemonic codes, opcode values, field bit positions and an opcode lookup.
package mips_isa_pkg;

  // Code 13 is held for SLTI. It cannot be encoded because its opcode would collide with LW.
  typedef enum logic [3:0] {
    MN_RTYPE    = 4'd0,
    MN_LW       = 4'd1,
    MN_SW       = 4'd2,
    MN_BEQ      = 4'd3,
    MN_BNE      = 4'd4,
    MN_ADDI     = 4'd5,
    MN_ADDIU    = 4'd6,
    MN_ANDI     = 4'd7,
    MN_ORI      = 4'd8,
    MN_ANDIU    = 4'd9,
    MN_ORIU     = 4'd10,
    MN_SLTIU    = 4'd11,
    MN_J        = 4'd12,
    MN_SLTI_RSV = 4'd13
  } mnem_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b100101;
  localparam logic [5:0] OP_ORI   = 6'b100111;
  localparam logic [5:0] OP_ANDIU = 6'b100100;
  localparam logic [5:0] OP_ORIU  = 6'b100110;
  localparam logic [5:0] OP_SLTIU = 6'b100010;
  localparam logic [5:0] OP_J     = 6'b000001;

  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned RS_MSB  = 25;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_MSB  = 20;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RD_MSB  = 15;
  localparam int unsigned RD_LSB  = 11;
  localparam int unsigned SH_MSB  = 10;
  localparam int unsigned SH_LSB  = 6;
  localparam int unsigned FN_MSB  = 5;
  localparam int unsigned FN_LSB  = 0;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned TGT_MSB = 25;
  localparam int unsigned TGT_LSB = 0;

  function automatic logic [5:0] opcode_of(input mnem_e m);
    case (m)
      MN_LW:    return OP_LW;
      MN_SW:    return OP_SW;
      MN_BEQ:   return OP_BEQ;
      MN_BNE:   return OP_BNE;
      MN_ADDI:  return OP_ADDI;
      MN_ADDIU: return OP_ADDIU;
      MN_ANDI:  return OP_ANDI;
      MN_ORI:   return OP_ORI;
      MN_ANDIU: return OP_ANDIU;
      MN_ORIU:  return OP_ORIU;
      MN_SLTIU: return OP_SLTIU;
      MN_J:     return OP_J;
      default:  return OP_RTYPE;
    endcase
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: mnemonic plus operand fields -> 32-bit word.
// Illegal mnemonics yield an all-zero word and assert illegal.
module instr_pack
  import mips_isa_pkg::*;
(
  input  logic [3:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // Place each field according to the instruction format of the mnemonic.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (mnem)
      MN_RTYPE: begin
        word[OP_MSB:OP_LSB] = OP_RTYPE;
        word[RS_MSB:RS_LSB] = rs;
        word[RT_MSB:RT_LSB] = rt;
        word[RD_MSB:RD_LSB] = rd;
        word[SH_MSB:SH_LSB] = '0;
        word[FN_MSB:FN_LSB] = funct;
      end
      MN_LW, MN_SW, MN_BEQ, MN_BNE, MN_ADDI, MN_ADDIU,
      MN_ANDI, MN_ORI, MN_ANDIU, MN_ORIU, MN_SLTIU: begin
        word[OP_MSB:OP_LSB]   = opcode_of(mnem_e'(mnem));
        word[RS_MSB:RS_LSB]   = rs;
        word[RT_MSB:RT_LSB]   = rt;
        word[IMM_MSB:IMM_LSB] = imm;
      end
      MN_J: begin
        word[OP_MSB:OP_LSB]   = OP_J;
        word[TGT_MSB:TGT_LSB] = target;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts descriptors, packs them into 32-bit words and
// writes them to sequential instruction-memory addresses starting at BASE_ADDR.
// Define ENC_ILLEGAL_CHECK_EN to flag and drop illegal mnemonics. When it is
// undefined, an illegal mnemonic is written as a NOP word.
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        mnem,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

`ifdef ENC_ILLEGAL_CHECK_EN
  localparam bit DROP_ILLEGAL = 1'b1;
`else
  localparam bit DROP_ILLEGAL = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  // BASE_ADDR+2^ADDR_W-1 falls inside the address space only when BASE_ADDR is 0.
  // In that case it equals the all-ones address, so a single compare covers both limits.
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {S_IDLE, S_WRITE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                full_q, full_d;
  logic                err_q, err_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                armed_q;
  logic [31:0]         pack_word;
  logic                pack_illegal;
  logic                accept;

  instr_pack u_pack (
    .mnem    (mnem),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .funct   (funct),
    .imm     (imm),
    .target  (target),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  // armed_q keeps in_ready low until the first clock edge after reset release.
  assign in_ready   = armed_q & ~full_q & ~start & ~rst;
  assign accept     = in_valid & in_ready;
  assign mem_we     = (state_q == S_WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign full       = full_q;
  assign err        = err_q;
  assign word_count = cnt_q;

  // Next state: start rewinds. Otherwise an accepted descriptor becomes a one-cycle write.
  always_comb begin
    state_d = S_IDLE;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    full_d  = full_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (start) begin
      ptr_d  = BASE;
      full_d = 1'b0;
      err_d  = 1'b0;
      cnt_d  = '0;
    end else if (accept) begin
      if (DROP_ILLEGAL && pack_illegal) begin
        err_d = 1'b1;
      end else begin
        state_d = S_WRITE;
        addr_d  = ptr_q;
        wdata_d = pack_illegal ? '0 : pack_word;
        cnt_d   = cnt_q + (ADDR_W+1)'(1);
        if (ptr_q == LAST) full_d = 1'b1;
        else               ptr_d  = ptr_q + ADDR_W'(1);
      end
    end
  end

  // State, pointer and flag registers, all cleared by asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= BASE;
      addr_q  <= BASE;
      wdata_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      full_q  <= full_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      armed_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: two instances (ADDR_W=8 and ADDR_W=2) driven by the
// same stimulus and checked every cycle against a behavioural model. A set of
// literal expectations pins the model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  mnem = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic [5:0]  funct = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;

  logic        a_ready, a_we, a_full, a_err;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic [8:0]  a_cnt;
  logic        b_ready, b_we, b_full, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(a_ready),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .target(target),
    .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .full(a_full), .err(a_err), .word_count(a_cnt)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(b_ready),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .target(target),
    .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .full(b_full), .err(b_err), .word_count(b_cnt)
  );

  // ---------------- behavioural model ----------------
  function automatic int aw(input int d);
    return (d == 0) ? 8 : 2;
  endfunction

  function automatic logic [31:0] ref_word(input int mn, input logic [4:0] s, input logic [4:0] t,
                                           input logic [4:0] dd, input logic [5:0] f,
                                           input logic [15:0] im, input logic [25:0] tg);
    int opc [13] = '{0, 35, 43, 4, 5, 8, 9, 37, 39, 36, 38, 34, 1};
    if (mn > 12) return 32'h0;
    if (mn == 0) return {6'd0, s, t, dd, 5'd0, f};
    if (mn == 12) return {6'(opc[12]), tg};
    return {6'(opc[mn]), s, t, im};
  endfunction

  bit          m_rdy [2];
  bit          m_we [2];
  bit          m_full [2];
  bit          m_err [2];
  int          m_addr [2];
  int          m_ptr [2];
  int          m_cnt [2];
  logic [31:0] m_data [2];
  bit          m_acc;

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_rdy[d] = 0; m_we[d] = 0; m_full[d] = 0; m_err[d] = 0;
        m_addr[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0; m_data[d] = '0;
      end else begin
        m_acc = m_rdy[d] && !m_full[d] && !start && in_valid;
        m_rdy[d] = 1;
        m_we[d] = 0;
        if (start) begin
          m_ptr[d] = 0; m_full[d] = 0; m_err[d] = 0; m_cnt[d] = 0;
        end else if (m_acc) begin
`ifdef ENC_ILLEGAL_CHECK_EN
          if (mnem > 12) m_err[d] = 1;
          else begin
`else
          begin
`endif
            m_we[d] = 1;
            m_addr[d] = m_ptr[d];
            m_data[d] = ref_word(int'(mnem), rs, rt, rd, funct, imm, target);
            m_cnt[d]++;
            if (m_ptr[d] == (1 << aw(d)) - 1) m_full[d] = 1;
            else m_ptr[d]++;
          end
        end
      end
    end
  end

  task automatic cmp(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL dut%0d %s: got %h expected %h at %0t", d, nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    cmp(0, "mem_we",     32'(a_we),    32'(m_we[0]));
    cmp(0, "mem_addr",   32'(a_addr),  32'(m_addr[0]));
    cmp(0, "mem_wdata",  a_wdata,      m_data[0]);
    cmp(0, "full",       32'(a_full),  32'(m_full[0]));
    cmp(0, "err",        32'(a_err),   32'(m_err[0]));
    cmp(0, "word_count", 32'(a_cnt),   32'(m_cnt[0]));
    cmp(0, "in_ready",   32'(a_ready), 32'(m_rdy[0] && !m_full[0] && !start && !rst));
    cmp(1, "mem_we",     32'(b_we),    32'(m_we[1]));
    cmp(1, "mem_addr",   32'(b_addr),  32'(m_addr[1]));
    cmp(1, "mem_wdata",  b_wdata,      m_data[1]);
    cmp(1, "full",       32'(b_full),  32'(m_full[1]));
    cmp(1, "err",        32'(b_err),   32'(m_err[1]));
    cmp(1, "word_count", 32'(b_cnt),   32'(m_cnt[1]));
    cmp(1, "in_ready",   32'(b_ready), 32'(m_rdy[1] && !m_full[1] && !start && !rst));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_desc(input logic [3:0] mn, input logic [4:0] s, input logic [4:0] t,
                          input logic [4:0] dd, input logic [5:0] f,
                          input logic [15:0] im, input logic [25:0] tg);
    in_valid = 1'b1; mnem = mn; rs = s; rt = t; rd = dd; funct = f; imm = im; target = tg;
  endtask

  task automatic send(input logic [3:0] mn, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] dd, input logic [5:0] f,
                      input logic [15:0] im, input logic [25:0] tg);
    set_desc(mn, s, t, dd, f, im, tg);
    step();
  endtask

  task automatic pulse_start();
    in_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    @(posedge clk);
    step();
    cmp(0, "lit_rst_ready", 32'(a_ready), 32'd0);
    cmp(0, "lit_rst_we",    32'(a_we),    32'd0);
    cmp(0, "lit_rst_addr",  32'(a_addr),  32'd0);
    cmp(0, "lit_rst_wdata", a_wdata,      32'd0);
    cmp(0, "lit_rst_cnt",   32'(a_cnt),   32'd0);
    cmp(0, "lit_rst_flags", 32'({a_full, a_err}), 32'd0);
    rst = 1'b0;
    step();
    cmp(0, "lit_ready_after_rst", 32'(a_ready), 32'd1);

    // LW: single write one cycle after acceptance
    send(4'd1, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0004, 26'd0);
    in_valid = 1'b0;
    @(negedge clk);
    cmp(0, "lit_lw_we",    32'(a_we),   32'd1);
    cmp(0, "lit_lw_addr",  32'(a_addr), 32'd0);
    cmp(0, "lit_lw_wdata", a_wdata,     32'h8C430004);
    step();

    // RTYPE then J, back to back
    pulse_start();
    fork
      begin
        send(4'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0);
        send(4'd12, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000010);
        in_valid = 1'b0;
      end
      begin
        @(negedge clk);
        @(negedge clk);
        cmp(0, "lit_r_we",    32'(a_we),   32'd1);
        cmp(0, "lit_r_addr",  32'(a_addr), 32'd0);
        cmp(0, "lit_r_wdata", a_wdata,     32'h00221820);
        @(negedge clk);
        cmp(0, "lit_j_we",    32'(a_we),   32'd1);
        cmp(0, "lit_j_addr",  32'(a_addr), 32'd1);
        cmp(0, "lit_j_wdata", a_wdata,     32'h04000010);
        cmp(0, "lit_j_cnt",   32'(a_cnt),  32'd2);
      end
    join
    step();

    // Fill the ADDR_W=2 instance: four ADDI writes, then a fifth offer is refused
    pulse_start();
    fork
      begin
        for (int i = 0; i < 5; i++) send(4'd5, 5'd1, 5'd1, 5'd0, 6'd0, 16'(i), 26'd0);
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(negedge clk);
        cmp(1, "lit_fill4_we",    32'(b_we),    32'd1);
        cmp(1, "lit_fill4_addr",  32'(b_addr),  32'd3);
        cmp(1, "lit_fill4_full",  32'(b_full),  32'd1);
        cmp(1, "lit_fill4_ready", 32'(b_ready), 32'd0);
        @(negedge clk);
        cmp(1, "lit_fill5_we",    32'(b_we),    32'd0);
        cmp(1, "lit_fill5_cnt",   32'(b_cnt),   32'd4);
      end
    join
    step();
    pulse_start();
    cmp(1, "lit_restart_full", 32'(b_full), 32'd0);
    send(4'd5, 5'd4, 5'd5, 5'd0, 6'd0, 16'hFFFF, 26'd0);
    in_valid = 1'b0;
    @(negedge clk);
    cmp(1, "lit_restart_we",    32'(b_we),   32'd1);
    cmp(1, "lit_restart_addr",  32'(b_addr), 32'd0);
    cmp(1, "lit_restart_wdata", b_wdata,     32'h2085FFFF);
    step();

    // Illegal mnemonic 13
    pulse_start();
    send(4'd13, 5'd1, 5'd2, 5'd3, 6'd4, 16'h1234, 26'd0);
    in_valid = 1'b0;
    @(negedge clk);
`ifdef ENC_ILLEGAL_CHECK_EN
    cmp(0, "lit_ill_we",  32'(a_we),  32'd0);
    cmp(0, "lit_ill_err", 32'(a_err), 32'd1);
    cmp(0, "lit_ill_cnt", 32'(a_cnt), 32'd0);
`else
    cmp(0, "lit_ill_we",    32'(a_we),   32'd1);
    cmp(0, "lit_ill_wdata", a_wdata,     32'd0);
    cmp(0, "lit_ill_addr",  32'(a_addr), 32'd0);
    cmp(0, "lit_ill_err",   32'(a_err),  32'd0);
`endif
    step();
    send(4'd8, 5'd0, 5'd0, 5'd0, 6'd0, 16'd1, 26'd0);
    in_valid = 1'b0;
    @(negedge clk);
`ifdef ENC_ILLEGAL_CHECK_EN
    cmp(0, "lit_after_ill_addr", 32'(a_addr), 32'd0);
`else
    cmp(0, "lit_after_ill_addr", 32'(a_addr), 32'd1);
`endif
    step();

    // Reset while an SW write is pending
    pulse_start();
    send(4'd2, 5'd6, 5'd7, 5'd0, 6'd0, 16'h0010, 26'd0);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    cmp(0, "lit_rstw_we",    32'(a_we),    32'd0);
    cmp(0, "lit_rstw_cnt",   32'(a_cnt),   32'd0);
    cmp(0, "lit_rstw_ready", 32'(a_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    cmp(0, "lit_release_ready", 32'(a_ready), 32'd0);
    step();
    cmp(0, "lit_armed_ready", 32'(a_ready), 32'd1);
    send(4'd1, 5'd0, 5'd0, 5'd0, 6'd0, 16'd8, 26'd0);
    in_valid = 1'b0;
    @(negedge clk);
    cmp(0, "lit_post_rst_we",   32'(a_we),   32'd1);
    cmp(0, "lit_post_rst_addr", 32'(a_addr), 32'd0);
    step();

    // start together with in_valid, with a write still pending at the old address
    send(4'd6, 5'd1, 5'd1, 5'd0, 6'd0, 16'd1, 26'd0);
    send(4'd6, 5'd1, 5'd1, 5'd0, 6'd0, 16'd2, 26'd0);
    start = 1'b1;
    set_desc(4'd8, 5'd7, 5'd9, 5'd0, 6'd0, 16'hBEEF, 26'd0);
    @(negedge clk);
    cmp(0, "lit_st_pend_we",   32'(a_we),   32'd1);
    cmp(0, "lit_st_pend_addr", 32'(a_addr), 32'd2);
    step();
    start = 1'b0;
    @(negedge clk);
    cmp(0, "lit_st_noacc_we", 32'(a_we),    32'd0);
    cmp(0, "lit_st_ready",    32'(a_ready), 32'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    cmp(0, "lit_st_we",    32'(a_we),   32'd1);
    cmp(0, "lit_st_addr",  32'(a_addr), 32'd0);
    cmp(0, "lit_st_wdata", a_wdata,     32'h9CE9BEEF);
    step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      mnem     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(13, 15)) : 4'($urandom_range(0, 12));
      rs       = 5'($urandom);
      rt       = 5'($urandom);
      rd       = 5'($urandom);
      funct    = 6'($urandom);
      imm      = 16'($urandom);
      target   = 26'($urandom);
      start    = ($urandom_range(0, 11) == 0);
      if (rst) rst = 1'b0;
      else     rst = ($urandom_range(0, 149) == 0);
      step();
    end
    in_valid = 1'b0;
    start = 1'b0;
    rst = 1'b0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
